execute_muldiv: RTL

Iterative multiply/divide functional unit for the execute stage, implementing the RV32M/RV64M operations over a parametrised data width. It sits beside the single-cycle ALU. It accepts one operation at a time from ID/EX, holds the pipeline via `busy` while iterating, and presents a registered result plus destination register to the EX→WB register. The radix-2 shift-add/restoring datapath trades latency for area. It adds multi-cycle operation, early-out special cases and flush abort, none of which the single-cycle ALU has.

---
 rtl/execute_muldiv_pkg.sv | 27 ++
 rtl/execute_muldiv.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_pkg.sv
// Shared M-extension opcode constants and FSM encoding for the iterative mul/div unit.
package execute_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Radix-2 iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one shared XLEN+1-bit adder, sign fix-up on the final iteration.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [4:0]      dest_reg_sel,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_dest_reg_sel
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] r_b;       // multiplicand / divisor magnitude
    logic [2:0]      r_op;
    logic            r_neg_lo;  // negate product or quotient
    logic            r_neg_hi;  // negate remainder
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_prev;
    logic [4:0]      r_dest;

    logic            w_s1, w_s2, w_div0, w_ovf, w_early;
    logic [XLEN-1:0] w_mag1, w_mag2, w_early_val;
    logic [XLEN:0]   w_add_a, w_add_b, w_sum;
    logic            w_cin;
    logic [XLEN-1:0] w_hi_n, w_lo_n, w_quo, w_rem, w_final;
    logic [2*XLEN-1:0] w_prod, w_prod_s;

    // Accept-side decode straight from ID/EX inputs
    assign w_s1   = rs1_signed(funct3) & operand1[XLEN-1];
    assign w_s2   = rs2_signed(funct3) & operand2[XLEN-1];
    assign w_mag1 = w_s1 ? -operand1 : operand1;
    assign w_mag2 = w_s2 ? -operand2 : operand2;
    assign w_div0 = (operand2 == '0);
    assign w_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (operand1 == MIN_NEG) && (&operand2);
    assign w_early = EARLY_OUT && funct3[2] && (w_div0 || w_ovf);

    always_comb begin
        w_early_val = '1;
        if (w_div0) w_early_val = funct3[1] ? operand1 : '1;
        else        w_early_val = funct3[1] ? '0 : MIN_NEG;
    end

    // Shared adder: add for multiply, subtract divisor for divide
    always_comb begin
        if (r_op[2]) begin
            w_add_a = {r_hi, r_lo[XLEN-1]};
            w_add_b = ~{1'b0, r_b};
            w_cin   = 1'b1;
        end else begin
            w_add_a = {1'b0, r_hi};
            w_add_b = r_lo[0] ? {1'b0, r_b} : '0;
            w_cin   = 1'b0;
        end
    end

    assign w_sum = w_add_a + w_add_b + {{XLEN{1'b0}}, w_cin};

    always_comb begin
        if (r_op[2]) begin
            // Negative difference means the trial subtract failed: keep the shifted remainder
            w_hi_n = w_sum[XLEN] ? w_add_a[XLEN-1:0] : w_sum[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], ~w_sum[XLEN]};
        end else begin
            {w_hi_n, w_lo_n} = {w_sum, r_lo[XLEN-1:1]};
        end
    end

    assign w_prod   = {w_hi_n, w_lo_n};
    assign w_prod_s = r_neg_lo ? -w_prod : w_prod;
    assign w_quo    = r_neg_lo ? -w_lo_n : w_lo_n;
    assign w_rem    = r_neg_hi ? -w_hi_n : w_hi_n;

    always_comb begin
        case (r_op)
            F3_MUL:                        w_final = w_prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  w_final = w_prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               w_final = w_quo;
            default:                       w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_result <= '0;
            r_prev   <= '0;
            r_dest   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        r_op   <= funct3;
                        r_dest <= dest_reg_sel;
                        r_cnt  <= CW'(XLEN-1);
                        r_hi   <= '0;
                        if (funct3[2]) begin
                            r_lo     <= w_mag1;
                            r_b      <= w_mag2;
                            // x/0 keeps the all-ones magnitude regardless of dividend sign
                            r_neg_lo <= (w_s1 ^ w_s2) & ~w_div0;
                            r_neg_hi <= w_s1;
                        end else begin
                            r_lo     <= w_mag2;
                            r_b      <= w_mag1;
                            r_neg_lo <= w_s1 ^ w_s2;
                            r_neg_hi <= 1'b0;
                        end
                        if (w_early) begin
                            r_prev   <= r_result;
                            r_result <= w_early_val;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_hi  <= w_hi_n;
                        r_lo  <= w_lo_n;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) begin
                            r_prev   <= r_result;
                            r_result <= w_final;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    // A flushed completion must leave the last architectural result visible
                    if (flush) r_result <= r_prev;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy            = (r_state != ST_IDLE);
    assign done            = (r_state == ST_DONE) && !flush;
    assign result          = r_result;
    assign wb_dest_reg_sel = r_dest;

endmodule
